// File: rtl/ad7276_emulator_if.sv
// AXI-Stream sample feed for ad7276_emulator: one {ch2, ch1} word per conversion frame.
interface ad7276_emulator_if #(
  parameter int unsigned AXIS_BYTES = 4
) ();
  logic [8*AXIS_BYTES-1:0] s_axis_tdata;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;

  modport master (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready
  );

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready
  );
endinterface

// File: rtl/ad7276_emulator.sv
// Responder end of a dual AD7276 cs/sclk/sdata link, fed by AXI-Stream sample words.
// cs and sclk are asynchronous and oversampled in the CLK100MHz domain.
module ad7276_emulator #(
  parameter int unsigned ADC_LENGTH    = 12,
  parameter int unsigned LEADING_ZEROS = 2,
  parameter int unsigned FRAME_BITS    = 16,
  parameter int unsigned AXIS_BYTES    = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                 CLK100MHz,
  input  logic                 ARESETN,
  ad7276_emulator_if.slave     s_axis,
  input  logic                 cs,
  input  logic                 sclk,
  output logic                 sdata1,
  output logic                 sdata2,
  output logic                 sdata_oe,
  output logic                 frame_done,
  output logic                 busy,
  output logic [15:0]          underrun_count
);

  localparam int unsigned TrailZeros = FRAME_BITS - LEADING_ZEROS - ADC_LENGTH;
  localparam int unsigned DataW      = 2 * ADC_LENGTH;
  localparam int unsigned CntW       = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  if (FRAME_BITS < LEADING_ZEROS + ADC_LENGTH) begin : g_bad_frame
    $error("FRAME_BITS too small for LEADING_ZEROS + ADC_LENGTH");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (8 * AXIS_BYTES < 16 + ADC_LENGTH) begin : g_bad_axis
    $error("s_axis_tdata too narrow for channel 2");
  end

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d, sclk_sync_q, sclk_sync_d;
  logic                    cs_dly_q, sclk_dly_q;
  logic [FRAME_BITS-1:0]   shift1_q, shift1_d, shift2_q, shift2_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    oe_q, oe_d, busy_q, busy_d, done_q, done_d;
  logic [15:0]             underrun_q, underrun_d;
  logic [DataW-1:0]        hold_q, hold_d, last_q, last_d, frame_val_q, frame_val_d;
  logic                    hold_full_q, hold_full_d;
  logic [DataW-1:0]        src;

  logic cs_s, sclk_s, cs_fall, cs_rise, sclk_fall, frame_start, accept;
  logic unused_tdata;

  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [ADC_LENGTH-1:0] d);
    logic [FRAME_BITS-1:0] w;
    w = FRAME_BITS'(d);
    return w << TrailZeros;
  endfunction

  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_fall     = cs_dly_q & ~cs_s;
  assign cs_rise     = ~cs_dly_q & cs_s;
  assign sclk_fall   = sclk_dly_q & ~sclk_s;
  // Frame start frees the holding register in the same cycle, so a new word can land now.
  assign frame_start = (state_q == StIdle) & cs_fall;
  assign s_axis.s_axis_tready = ~hold_full_q | frame_start;
  assign accept      = s_axis.s_axis_tvalid & s_axis.s_axis_tready;
  assign unused_tdata = ^s_axis.s_axis_tdata;

  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};

    state_d     = state_q;
    shift1_d    = shift1_q;
    shift2_d    = shift2_q;
    cnt_d       = cnt_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    underrun_d  = underrun_q;
    last_d      = last_q;
    frame_val_d = frame_val_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    src         = hold_full_q ? hold_q : last_q;

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          if (!hold_full_q && underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
          shift1_d    = frame_word(src[ADC_LENGTH-1:0]);
          shift2_d    = frame_word(src[DataW-1:ADC_LENGTH]);
          frame_val_d = src;
          hold_full_d = 1'b0;
          oe_d        = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = '0;
          state_d     = StShift;
        end
      end
      StShift: begin
        if (cs_rise) begin
          oe_d    = 1'b0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (sclk_fall) begin
          if (cnt_q == CntW'(FRAME_BITS - 1)) begin
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            last_d  = frame_val_q;
            state_d = StDone;
          end else begin
            cnt_d    = cnt_q + 1'b1;
            shift1_d = shift1_q << 1;
            shift2_d = shift2_q << 1;
          end
        end
      end
      StDone: begin
        if (cs_rise) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      hold_d      = {s_axis.s_axis_tdata[16+ADC_LENGTH-1:16],
                     s_axis.s_axis_tdata[ADC_LENGTH-1:0]};
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge CLK100MHz or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= StIdle;
      cs_sync_q   <= '1;
      sclk_sync_q <= '1;
      cs_dly_q    <= 1'b1;
      sclk_dly_q  <= 1'b1;
      shift1_q    <= '0;
      shift2_q    <= '0;
      cnt_q       <= '0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= '0;
      last_q      <= '0;
      frame_val_q <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      cs_dly_q    <= cs_s;
      sclk_dly_q  <= sclk_s;
      shift1_q    <= shift1_d;
      shift2_q    <= shift2_d;
      cnt_q       <= cnt_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      last_q      <= last_d;
      frame_val_q <= frame_val_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  // Gating by oe keeps the pins at 0 whenever the modelled driver is high-Z.
  assign sdata1         = oe_q & shift1_q[FRAME_BITS-1];
  assign sdata2         = oe_q & shift2_q[FRAME_BITS-1];
  assign sdata_oe       = oe_q;
  assign frame_done     = done_q;
  assign busy           = busy_q;
  assign underrun_count = underrun_q;

endmodule

// File: tb/tb_ad7276_emulator.sv
// Directed bench for ad7276_emulator: frames, underruns, abort, backpressure, async reset.
module tb_ad7276_emulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs, sclk;
  logic        sdata1, sdata2, sdata_oe, frame_done, busy;
  logic [15:0] underrun_count;

  int tests  = 0;
  int failed = 0;
  int fd_cnt = 0;

  always #5 clk = ~clk;

  ad7276_emulator_if #(.AXIS_BYTES(4)) axis ();

  ad7276_emulator dut (
    .CLK100MHz     (clk),
    .ARESETN       (rst_n),
    .s_axis        (axis),
    .cs            (cs),
    .sclk          (sclk),
    .sdata1        (sdata1),
    .sdata2        (sdata2),
    .sdata_oe      (sdata_oe),
    .frame_done    (frame_done),
    .busy          (busy),
    .underrun_count(underrun_count)
  );

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cs = 1'b1;
    sclk = 1'b1;
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tdata = '0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(5);
  endtask

  task automatic axis_write(input logic [31:0] w);
    check_eq("tready_before_write", axis.s_axis_tready, 1);
    axis.s_axis_tdata = w;
    axis.s_axis_tvalid = 1'b1;
    wait_cyc(1);
    axis.s_axis_tvalid = 1'b0;
  endtask

  // Leaves cs low; the caller raises it (end_frame or an abort).
  task automatic run_frame(input int nfalls, output logic [15:0] b1, output logic [15:0] b2);
    b1 = '0;
    b2 = '0;
    cs = 1'b0;
    wait_cyc(5);
    check_eq("oe_at_start", sdata_oe, 1);
    check_eq("busy_at_start", busy, 1);
    b1[15] = sdata1;
    b2[15] = sdata2;
    for (int k = 1; k <= nfalls; k++) begin
      sclk = 1'b0;
      wait_cyc(5);
      if (k < 16) begin
        b1[15-k] = sdata1;
        b2[15-k] = sdata2;
      end
      sclk = 1'b1;
      wait_cyc(5);
    end
    if (nfalls >= 16) begin
      check_eq("oe_after_frame", sdata_oe, 0);
      check_eq("sdata1_after_frame", sdata1, 0);
    end
  endtask

  task automatic end_frame();
    cs = 1'b1;
    wait_cyc(6);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] b1, b2;
    int fd0;

    // Reset values, sampled while reset is held.
    rst_n = 1'b0;
    cs = 1'b1;
    sclk = 1'b1;
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tdata = '0;
    wait_cyc(3);
    check_eq("rst_tready", axis.s_axis_tready, 1);
    check_eq("rst_oe", sdata_oe, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_underrun", underrun_count, 0);
    check_eq("rst_sdata", {sdata1, sdata2}, 0);
    check_eq("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Basic frame.
    axis_write(32'h0ABC_0123);
    check_eq("tready_full", axis.s_axis_tready, 0);
    fd0 = fd_cnt;
    run_frame(16, b1, b2);
    end_frame();
    check_eq("s1_ch1", b1, 16'h048C);
    check_eq("s1_ch2", b2, 16'h2AF0);
    check_eq("s1_frame_done", fd_cnt - fd0, 1);
    check_eq("s1_underrun", underrun_count, 0);
    check_eq("s1_tready", axis.s_axis_tready, 1);

    // Underruns from reset, then a fresh all-ones word.
    do_reset();
    run_frame(16, b1, b2);
    end_frame();
    check_eq("u1_ch1", b1, 0);
    check_eq("u1_ch2", b2, 0);
    run_frame(16, b1, b2);
    end_frame();
    check_eq("u2_ch1", b1, 0);
    check_eq("u2_underrun", underrun_count, 2);
    axis_write(32'h0FFF_0FFF);
    run_frame(16, b1, b2);
    end_frame();
    check_eq("u3_ch1", b1, 16'h3FFC);
    check_eq("u3_ch2", b2, 16'h3FFC);
    check_eq("u3_underrun", underrun_count, 2);

    // Last-sample repeat on underrun.
    do_reset();
    axis_write(32'h0000_0555);
    run_frame(16, b1, b2);
    end_frame();
    check_eq("ra_ch1", b1, 16'h1554);
    run_frame(16, b1, b2);
    end_frame();
    check_eq("rb_ch1", b1, 16'h1554);
    check_eq("rb_ch2", b2, 0);
    check_eq("rb_underrun", underrun_count, 1);

    // Abort after 7 falling edges.
    axis_write(32'h0ABC_0123);
    fd0 = fd_cnt;
    run_frame(7, b1, b2);
    check_eq("ab_partial", b1[15:8], 8'h04);
    cs = 1'b1;
    wait_cyc(3);
    check_eq("ab_oe", sdata_oe, 0);
    check_eq("ab_busy", busy, 0);
    wait_cyc(3);
    check_eq("ab_no_done", fd_cnt - fd0, 0);
    axis_write(32'h0ABC_0123);
    run_frame(16, b1, b2);
    end_frame();
    check_eq("ab_next_ch1", b1, 16'h048C);
    check_eq("ab_next_ch2", b2, 16'h2AF0);
    check_eq("ab_underrun", underrun_count, 1);

    // Backpressure: second word waits until the next frame start.
    axis_write(32'h0111_0222);
    axis.s_axis_tdata = 32'h0333_0444;
    axis.s_axis_tvalid = 1'b1;
    wait_cyc(3);
    check_eq("bp_tready_low", axis.s_axis_tready, 0);
    run_frame(16, b1, b2);
    end_frame();
    axis.s_axis_tvalid = 1'b0;
    check_eq("bp_f1_ch1", b1, 16'h0888);
    check_eq("bp_f1_ch2", b2, 16'h0444);
    check_eq("bp_held", axis.s_axis_tready, 0);
    run_frame(16, b1, b2);
    end_frame();
    check_eq("bp_f2_ch1", b1, 16'h1110);
    check_eq("bp_f2_ch2", b2, 16'h0CCC);
    check_eq("bp_underrun", underrun_count, 1);
    check_eq("bp_tready_end", axis.s_axis_tready, 1);

    // Asynchronous reset in the middle of a frame.
    axis_write(32'h0ABC_0123);
    fd0 = fd_cnt;
    run_frame(9, b1, b2);
    check_eq("mr_oe_before", sdata_oe, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mr_oe", sdata_oe, 0);
    check_eq("mr_busy", busy, 0);
    check_eq("mr_sdata", {sdata1, sdata2}, 0);
    check_eq("mr_underrun", underrun_count, 0);
    check_eq("mr_tready", axis.s_axis_tready, 1);
    check_eq("mr_frame_done", frame_done, 0);
    cs = 1'b1;
    sclk = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(5);
    check_eq("mr_no_done", fd_cnt - fd0, 0);
    axis_write(32'h0ABC_0123);
    fd0 = fd_cnt;
    run_frame(16, b1, b2);
    end_frame();
    check_eq("mr_ch1", b1, 16'h048C);
    check_eq("mr_ch2", b2, 16'h2AF0);
    check_eq("mr_done", fd_cnt - fd0, 1);
    check_eq("mr_underrun_after", underrun_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
